// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS core.
// Contents: word width, opcode encodings, instruction field positions,
// the fetch FSM state type and a helper that extracts the opcode field.
package mips16_pkg;

    localparam int WORD_W = 16;

    // Opcode encodings (instruction bits [15:13])
    localparam logic [2:0] OPC_RTYPE = 3'b000;
    localparam logic [2:0] OPC_LW    = 3'b001;
    localparam logic [2:0] OPC_SW    = 3'b010;
    localparam logic [2:0] OPC_ADDI  = 3'b011;
    localparam logic [2:0] OPC_BEQ   = 3'b100;
    localparam logic [2:0] OPC_HALT  = 3'b111;

    // Instruction field positions
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 13;
    localparam int RS_MSB    = 12;
    localparam int RS_LSB    = 9;
    localparam int RT_MSB    = 8;
    localparam int RT_LSB    = 5;
    localparam int FUNCT_MSB = 2;
    localparam int FUNCT_LSB = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory and decode.
//   imem_addr/imem_rdata   : instruction memory address and combinational read data
//   inst_valid/inst_ready  : decode handshake for the FIFO head
//   inst_out/inst_pc       : head instruction word and the address it came from
//   redirect/redirect_pc   : taken branch/jump and its target
//   halted                 : HALT fetched, fetching stopped
// Modport master is the fetch sequencer; slave is memory plus decode.
interface fetch_sequencer_if;
    import mips16_pkg::*;

    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [WORD_W-1:0] inst_out;
    logic [WORD_W-1:0] inst_pc;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              halted;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_out,
        output inst_pc,
        input  redirect,
        input  redirect_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_out,
        input  inst_pc,
        output redirect,
        output redirect_pc,
        input  halted
    );

endinterface

// File: rtl/fetch_sequencer_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO holding {instruction, pc} pairs.
//   clk, rst : clock, asynchronous active-high reset
//   flush    : drop all entries (wins over push and pop)
//   push/din : write din at the tail
//   pop      : retire the head
//   head     : head entry, or the last shown head while empty
//   count    : number of stored entries
//   valid    : count != 0
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic [WIDTH-1:0] last_reg;
    logic             full, do_push, do_pop;

    assign valid = (count_reg != '0);
    assign full  = (count_reg == (PTR_W+1)'(DEPTH));

    // A slot freed by a pop in the same cycle can take the incoming word.
    assign do_pop  = pop & valid & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_comb begin
        count_next = count_reg;
        if (flush)
            count_next = '0;
        else if (do_push & ~do_pop)
            count_next = count_reg + 1'b1;
        else if (do_pop & ~do_push)
            count_next = count_reg - 1'b1;
    end

    // Storage has no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_reg[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            last_reg   <= '0;
        end else begin
            count_reg <= count_next;
            if (valid)
                last_reg <= mem_reg[rd_ptr_reg];
            if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (do_push)
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (do_pop)
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // While empty, keep presenting whatever decode last saw.
    assign head  = valid ? mem_reg[rd_ptr_reg] : last_reg;
    assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for the 16-bit MIPS core.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fetch_sequencer_if.master (memory address/data, decode
//              handshake, redirect input, halted status)
// Owns the PC, pushes {word, pc} into the prefetch FIFO whenever there is
// room, stops after a HALT opcode and restarts on redirect.
module fetch_sequencer
    import mips16_pkg::*;
#(
    parameter int unsigned       DEPTH    = 2,
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter logic [2:0]        HALT_OPC = OPC_HALT
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0]   pc_reg, pc_next;
    fetch_state_t        state_reg, state_next;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_valid;
    logic [2*WORD_W-1:0] fifo_head;
    logic                pop, space, push, is_halt;

    assign pop     = fifo_valid & bus.inst_ready;
    assign space   = (fifo_count < CNT_W'(DEPTH)) | pop;
    assign is_halt = (opcode_of(bus.imem_rdata) == HALT_OPC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            state_reg <= ST_RUN;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= state_next;
        end
    end

    // Redirect wins over everything. The HALT word is still pushed so decode
    // sees it, but the PC stays parked on it.
    always_comb begin
        push       = 1'b0;
        pc_next    = pc_reg;
        state_next = state_reg;
        if (bus.redirect) begin
            pc_next    = bus.redirect_pc;
            state_next = ST_RUN;
        end else if (state_reg == ST_RUN && space) begin
            push = 1'b1;
            if (is_halt)
                state_next = ST_HALT;
            else
                pc_next = pc_reg + WORD_W'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (push),
        .pop   (pop),
        .din   ({bus.imem_rdata, pc_reg}),
        .head  (fifo_head),
        .count (fifo_count),
        .valid (fifo_valid)
    );

    assign bus.imem_addr  = pc_reg;
    assign bus.inst_valid = fifo_valid;
    assign bus.inst_out   = fifo_head[2*WORD_W-1:WORD_W];
    assign bus.inst_pc    = fifo_head[WORD_W-1:0];
    assign bus.halted     = (state_reg == ST_HALT);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the 16-bit MIPS core.
- Owns the program counter and drives the address of the combinational-read instruction memory.
- Captures each fetched word, tagged with its PC, into a small prefetch FIFO.
- Hands words to decode over a valid/ready handshake, handling branch/jump redirects and a HALT opcode.

Parameters:
- DEPTH, 2, prefetch FIFO entries (power of two, >=2).
- RESET_PC, 16'h0000, PC loaded on reset.
- HALT_OPC, 3'b111, opcode field [15:13] that stops fetching.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  16  word address to instruction memory; equals internal PC.
- imem_rdata  in  16  instruction word, combinationally valid for imem_addr in the same cycle.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_out  out  16  head instruction word.
- inst_pc  out  16  address that inst_out was fetched from.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  16  new fetch address when redirect=1.
- halted  out  1  HALT fetched; fetching stopped.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; FIFO empty (count=0, pointers 0).
  - inst_valid=0, inst_out=0, inst_pc=0, halted=0, FSM=RUN.
- FSM states: RUN, HALT.
  - RUN->HALT when a pushed word has opcode [15:13]==HALT_OPC.
  - HALT->RUN only on redirect.
  - Reset always goes to RUN.
- Definitions:
  - pop = inst_valid & inst_ready.
  - space = (count<DEPTH) | pop.
- Push occurs when FSM=RUN & space & !redirect:
  - writes {imem_rdata, pc} at the tail.
  - pc <= pc+1, wrapping 16'hFFFF->16'h0000.
- HALT word handling: the HALT word itself is pushed and delivered to decode; pc is NOT incremented past it and FSM enters HALT. In HALT: no push, pc holds.
- Redirect has highest priority:
  - FIFO flushed (count=0); any pop that same cycle is discarded, not delivered twice.
  - pc <= redirect_pc; FSM <= RUN; no push that cycle.
- Full FIFO without pop: no push, pc holds, imem_addr stable.
- Full FIFO with pop: push and pop in the same cycle, count unchanged.
- Count update: count' = count + push - pop (0 on redirect).
- Outputs:
  - inst_valid = (count!=0).
  - inst_out/inst_pc come from head storage (registered entries, combinational head select).
  - When inst_valid=0, inst_out/inst_pc hold their last value; decode must ignore them.
- Latency: word at address A is on inst_out one cycle after pc==A, given space.
- Throughput: 1 instruction/cycle sustained with inst_ready held high.
- halted = (FSM==HALT). It stays asserted while the HALT word drains.
- rst asserted mid-operation: immediate return to reset values; FIFO contents lost.

Decomposition:
- Shared package mips16_pkg:
  - WORD_W=16.
  - Opcode constants: OPC_RTYPE=3'b000, OPC_LW=3'b001, OPC_SW=3'b010, OPC_ADDI=3'b011, OPC_BEQ=3'b100, OPC_HALT=3'b111.
  - Field slice constants: opcode [15:13], rs [12:9], rt [8:5], funct [2:0].
  - The fetch FSM state enum.
- One sub-module, fetch_fifo: DEPTH-entry, 32-bit-wide synchronous FIFO with push/pop/flush, count, and head outputs.
- PC and FSM stay in fetch_sequencer.

Test Plan:
- Reset, then inst_ready=1, memory image 0:0x1FC0, 1:0x1FC1, 2:0x1FC3 -> inst_out 0x1FC0/0x1FC1/0x1FC3 with inst_pc 0/1/2 on consecutive cycles, first one cycle after reset release.
- inst_ready=0 for 5 cycles -> count saturates at 2, imem_addr stops at 16'h0002, inst_out stays 0x1FC0. Raising ready then resumes in order with no loss or duplication.
- Redirect to 16'h0040 while FIFO holds 2 entries and ready=1 -> next cycle inst_valid=0, imem_addr=16'h0040. Following cycle inst_pc=16'h0040; flushed words never appear.
- Memory word 0xE000 at address 3 -> 0xE000 delivered with inst_pc=3, halted=1, imem_addr holds 3, inst_valid drops after it drains. Redirect to 0 clears halted and fetch restarts at 0.
- pc=16'hFFFF with valid fetch -> next imem_addr=16'h0000, inst_pc sequence FFFF then 0000.
- rst pulsed asynchronously mid-stream with FIFO non-empty -> inst_valid=0, halted=0, imem_addr=RESET_PC immediately, before the next clock edge.
